// File: rtl/ctrl_pkg.sv
// Shared types and helpers for the I2S receive capture block: serial standard,
// capture state and word-length decode.
package ctrl_pkg;

  typedef enum logic [1:0] {PHILIPS, MSB_J, LSB_J} rx_std_t;

  typedef enum logic [1:0] {IDLE, SYNCED, DELAY, SHIFT} rx_state_t;

  // std_sel 3 is an alias of Philips.
  function automatic rx_std_t std_decode(input logic [1:0] sel);
    case (sel)
      2'd1:    return MSB_J;
      2'd2:    return LSB_J;
      default: return PHILIPS;
    endcase
  endfunction

  function automatic logic [5:0] frame_len(input logic [1:0] sel);
    case (sel)
      2'd0:    return 6'd16;
      2'd1:    return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/i2s_rx_capture_if.sv
// Valid/ready word port of the I2S receiver: master is the receiver, slave the consumer.
interface i2s_rx_capture_if;
  import ctrl_pkg::*;

  logic [31:0] out_data;
  logic        out_right;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_right,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_right,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/i2s_pin_sync.sv
// Synchronizes the asynchronous sclk/ws/sd pins into clk_i and flags sclk rising edges
// against the registered previous synchronized sclk.
module i2s_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  input  logic ws_i,
  input  logic sd_i,
  output logic rise_o,
  output logic ws_s_o,
  output logic sd_s_o
);

  logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
  logic [SYNC_STAGES-1:0] ws_q, ws_d;
  logic [SYNC_STAGES-1:0] sd_q, sd_d;
  logic                   sclk_prev_q, sclk_prev_d;

  always_comb begin
    sclk_d      = {sclk_q[SYNC_STAGES-2:0], sclk_i};
    ws_d        = {ws_q[SYNC_STAGES-2:0], ws_i};
    sd_d        = {sd_q[SYNC_STAGES-2:0], sd_i};
    sclk_prev_d = sclk_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q      <= '0;
      ws_q        <= '0;
      sd_q        <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  assign rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign ws_s_o = ws_q[SYNC_STAGES-1];
  assign sd_s_o = sd_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx_capture.sv
// Oversampling I2S receiver: deserializes Philips / MSB- / LSB-justified words into a FIFO.
// Define I2S_RX_SIGN_EXT_EN to sign-extend words shorter than 32 bits.
module i2s_rx_capture
  import ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             en,
  input  logic [1:0]       std_sel,
  input  logic [1:0]       frame_sel,
  input  logic             stereo,
  input  logic             sclk_i,
  input  logic             ws_i,
  input  logic             sd_i,
  i2s_rx_capture_if.master out_if,
  output logic             ovf,
  output logic             frm_err,
  input  logic             err_clr
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] StIdle  = IDLE;
  localparam logic [1:0] StDelay = DELAY;
  localparam logic [1:0] StShift = SHIFT;

  logic rise, ws_s, sd_s;

  i2s_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk_i (pclk),
    .rst_i (preset),
    .sclk_i(sclk_i),
    .ws_i  (ws_i),
    .sd_i  (sd_i),
    .rise_o(rise),
    .ws_s_o(ws_s),
    .sd_s_o(sd_s)
  );

  rx_std_t    std;
  logic [5:0] frame_n;

  assign std     = std_decode(std_sel);
  assign frame_n = frame_len(frame_sel);

  // ---------------------------------------------------------------------------
  // Capture state machine, advanced only on synchronized sclk rising edges
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ws_prev_q, ws_prev_d;
  logic        have_ws_q, have_ws_d;
  logic        push_q, push_d;
  logic [31:0] push_data_q, push_data_d;
  logic        push_right_q, push_right_d;
  logic [31:0] push_src;
  logic        wsc;
  logic        frm_set;

  // A ws change needs a ws sample from an earlier rise, so reset never fakes one.
  assign wsc = rise & have_ws_q & (ws_s != ws_prev_q);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    ws_prev_d    = ws_prev_q;
    have_ws_d    = have_ws_q;
    push_d       = 1'b0;
    push_src     = shift_q;
    push_right_d = push_right_q;
    frm_set      = 1'b0;

    if (rise) begin
      ws_prev_d = ws_s;
      have_ws_d = 1'b1;
      if (wsc) begin
        if (state_q != StIdle) begin
          if (std == LSB_J) begin
            push_d       = stereo | ~ws_prev_q;
            push_src     = shift_q;
            push_right_d = ws_prev_q;
          end else if (cnt_q < frame_n) begin
            frm_set = 1'b1;
          end
        end
        if (std == PHILIPS) begin
          state_d = StDelay;
          shift_d = '0;
          cnt_d   = '0;
        end else begin
          state_d = StShift;
          shift_d = {31'd0, sd_s};
          cnt_d   = 6'd1;
        end
      end else begin
        case (state_q)
          StDelay: begin
            state_d = StShift;
            shift_d = {31'd0, sd_s};
            cnt_d   = 6'd1;
          end
          StShift: begin
            shift_d = {shift_q[30:0], sd_s};
            if (cnt_q != 6'd32) begin
              cnt_d = cnt_q + 6'd1;
            end
            // Saturating count crosses N exactly once per channel.
            if (std != LSB_J && cnt_q == frame_n - 6'd1) begin
              push_d       = stereo | ~ws_s;
              push_src     = shift_d;
              push_right_d = ws_s;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [32:0] mask_wide;
  logic [31:0] mask;
`ifdef I2S_RX_SIGN_EXT_EN
  logic [4:0]  sign_idx;
`endif

  always_comb begin
    mask_wide   = (33'd1 << frame_n) - 33'd1;
    mask        = mask_wide[31:0];
    push_data_d = push_src & mask;
`ifdef I2S_RX_SIGN_EXT_EN
    sign_idx = 5'(frame_n - 6'd1);
    if (push_src[sign_idx]) begin
      push_data_d = push_data_d | ~mask;
    end
`endif
  end

  always_ff @(posedge pclk) begin
    if (preset || !en) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      cnt_q        <= '0;
      ws_prev_q    <= 1'b0;
      have_ws_q    <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      push_right_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      ws_prev_q    <= ws_prev_d;
      have_ws_q    <= have_ws_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      push_right_q <= push_right_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO and sticky error flags
  // ---------------------------------------------------------------------------
  logic [32:0]  mem_q [FIFO_DEPTH];
  logic [AddrW:0] wptr_q, wptr_d;
  logic [AddrW:0] rptr_q, rptr_d;
  logic         empty, full, pop, push_ok, ovf_set;
  logic         ovf_q, ovf_d;
  logic         frm_err_q, frm_err_d;
  logic [32:0]  rd_word;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
              (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    pop     = ~empty & out_if.out_ready;
    // A pop in the same cycle frees the slot the push needs.
    push_ok = push_q & en & (~full | pop);
    ovf_set = push_q & en & full & ~pop;

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end

    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end

    frm_err_d = frm_err_q;
    if (frm_set && en) begin
      frm_err_d = 1'b1;
    end else if (err_clr) begin
      frm_err_d = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (push_ok) begin
      mem_q[wptr_q[AddrW-1:0]] <= {push_right_q, push_data_q};
    end
  end

  always_ff @(posedge pclk) begin
    if (preset || !en) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      ovf_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign rd_word          = mem_q[rptr_q[AddrW-1:0]];
  assign out_if.out_valid = ~empty;
  assign out_if.out_data  = empty ? 32'd0 : rd_word[31:0];
  assign out_if.out_right = ~empty & rd_word[32];
  assign ovf              = ovf_q;
  assign frm_err          = frm_err_q;

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Self-checking bench for i2s_rx_capture: directed vector table, corner-case sequences
// and randomized slot streams checked against a slot-level reference model.
module tb_i2s_rx_capture;

  localparam int unsigned FifoDepth  = 4;
  localparam int unsigned SyncStages = 2;
`ifdef I2S_RX_SIGN_EXT_EN
  localparam bit SignExt = 1'b1;
`else
  localparam bit SignExt = 1'b0;
`endif

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       en = 1'b0;
  logic [1:0] std_sel = 2'd0;
  logic [1:0] frame_sel = 2'd0;
  logic       stereo = 1'b1;
  logic       sclk_i = 1'b0;
  logic       ws_i = 1'b0;
  logic       sd_i = 1'b0;
  logic       err_clr = 1'b0;
  logic       ovf;
  logic       frm_err;

  i2s_rx_capture_if out_if();

  i2s_rx_capture #(
    .FIFO_DEPTH (FifoDepth),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .en       (en),
    .std_sel  (std_sel),
    .frame_sel(frame_sel),
    .stereo   (stereo),
    .sclk_i   (sclk_i),
    .ws_i     (ws_i),
    .sd_i     (sd_i),
    .out_if   (out_if),
    .ovf      (ovf),
    .frm_err  (frm_err),
    .err_clr  (err_clr)
  );

  always #5 pclk = ~pclk;

  int n_pass = 0;
  int n_checks = 0;

  // Serial line described as slots of constant ws; bits stored MSB = first sent.
  bit          slot_ws   [16];
  int          slot_len  [16];
  logic [63:0] slot_bits [16];
  int          n_slots = 0;

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  bit          exp_frm;
  int          rdy_mode = 1;

  typedef struct {
    logic [1:0]  std;
    logic [1:0]  fsel;
    logic        st;
    int          len;
    logic [31:0] w_l;
    logic [31:0] w_r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
    int          n_exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Consumer: chooses ready, then records a transfer that will happen at the next posedge.
  initial begin
    out_if.out_ready = 1'b0;
    forever begin
      @(negedge pclk);
      case (rdy_mode)
        0:       out_if.out_ready = 1'b0;
        1:       out_if.out_ready = 1'b1;
        default: out_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_if.out_valid && out_if.out_ready)
        got_q.push_back({out_if.out_right, out_if.out_data});
    end
  end

  function automatic int n_of(input logic [1:0] fsel);
    return (fsel == 2'd0) ? 16 : (fsel == 2'd1) ? 24 : 32;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] w, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++) r[i] = (i < n) ? w[i] : (SignExt ? w[n-1] : 1'b0);
    return r;
  endfunction

  // Lay out one channel word inside a slot of len bits; filler bits are ones.
  function automatic logic [63:0] make_slot(input logic [1:0] sstd, input int n, input int len,
                                            input logic [31:0] w);
    logic [63:0] v = '0;
    logic b;
    for (int p = 0; p < len; p++) begin
      if (sstd == 2'd2)      b = (p < len - n) ? 1'b1 : w[len-1-p];
      else if (sstd == 2'd1) b = (p < n) ? w[n-1-p] : 1'b1;
      else                   b = (p >= 1 && p <= n) ? w[n-p] : 1'b1;
      v[len-1-p] = b;
    end
    return v;
  endfunction

  task automatic add_raw(input bit ws, input int len, input logic [63:0] bits);
    slot_ws[n_slots]   = ws;
    slot_len[n_slots]  = len;
    slot_bits[n_slots] = bits;
    n_slots++;
  endtask

  task automatic add_word(input bit ws, input logic [1:0] sstd, input logic [1:0] fsel,
                          input int len, input logic [31:0] w);
    add_raw(ws, len, make_slot(sstd, n_of(fsel), len, w));
  endtask

  task automatic send_bit(input logic ws, input logic sd);
    sclk_i = 1'b0;
    ws_i   = ws;
    sd_i   = sd;
    repeat (4) @(negedge pclk);
    sclk_i = 1'b1;
    repeat (4) @(negedge pclk);
  endtask

  task automatic play();
    for (int i = 0; i < n_slots; i++)
      for (int p = 0; p < slot_len[i]; p++) send_bit(slot_ws[i], slot_bits[i][slot_len[i]-1-p]);
    n_slots = 0;
    repeat (40) @(negedge pclk);
  endtask

  task automatic setup(input logic [1:0] s, input logic [1:0] f, input logic st);
    @(negedge pclk);
    en = 1'b0;
    std_sel = s;
    frame_sel = f;
    stereo = st;
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    en = 1'b1;
    got_q.delete();
    n_slots = 0;
  endtask

  // Slot-level reference: every slot after the first opens with a ws change.
  task automatic model_run(input logic [1:0] s, input logic [1:0] f, input logic st);
    int n;
    int d;
    bit closed;
    bit have;
    logic [31:0] w;
    n = n_of(f);
    d = (s == 2'd0 || s == 2'd3) ? 1 : 0;
    exp_q.delete();
    exp_frm = 1'b0;
    for (int i = 1; i < n_slots; i++) begin
      closed = (i < n_slots - 1);
      have = 1'b0;
      w = '0;
      if (s == 2'd2) begin
        if (closed) begin
          w = slot_bits[i][31:0];
          have = 1'b1;
        end
      end else if (slot_len[i] - d >= n) begin
        w = 32'(slot_bits[i] >> (slot_len[i] - d - n));
        have = 1'b1;
      end else if (closed) begin
        exp_frm = 1'b1;
      end
      if (have && (st || !slot_ws[i])) exp_q.push_back({slot_ws[i], ext(w, n)});
    end
  endtask

  task automatic compare_all(input string name);
    check($sformatf("%s count", name), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s word%0d", name, i), got_q[i], exp_q[i]);
    check($sformatf("%s frm_err", name), frm_err, exp_frm);
    check($sformatf("%s ovf", name), ovf, 1'b0);
  endtask

  initial begin
    vecs[0] = '{2'd0, 2'd0, 1'b1, 32, 32'hA5C3, 32'h1234,
                SignExt ? 32'hFFFFA5C3 : 32'h0000A5C3, 32'h00001234, 2};
    vecs[1] = '{2'd1, 2'd1, 1'b1, 32, 32'h800001, 32'h7FFFFE,
                SignExt ? 32'hFF800001 : 32'h00800001, 32'h007FFFFE, 2};
    vecs[2] = '{2'd2, 2'd0, 1'b1, 32, 32'hBEEF, 32'h0F0F,
                SignExt ? 32'hFFFFBEEF : 32'h0000BEEF, 32'h00000F0F, 2};
    vecs[3] = '{2'd3, 2'd2, 1'b1, 33, 32'hDEADBEEF, 32'h01234567,
                32'hDEADBEEF, 32'h01234567, 2};
    vecs[4] = '{2'd2, 2'd1, 1'b1, 32, 32'hABCDEF, 32'h123456,
                SignExt ? 32'hFFABCDEF : 32'h00ABCDEF, 32'h00123456, 2};
    vecs[5] = '{2'd0, 2'd0, 1'b0, 32, 32'h8001, 32'h4444,
                SignExt ? 32'hFFFF8001 : 32'h00008001, 32'h0, 1};

    // Reset state
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    check("reset out_valid", out_if.out_valid, 1'b0);
    check("reset out_data", out_if.out_data, 32'd0);
    check("reset out_right", out_if.out_right, 1'b0);
    check("reset ovf", ovf, 1'b0);
    check("reset frm_err", frm_err, 1'b0);

    // Directed vector table
    for (int v = 0; v < 6; v++) begin
      rdy_mode = 1;
      setup(vecs[v].std, vecs[v].fsel, vecs[v].st);
      add_raw(1'b1, 2, 64'd0);
      add_word(1'b0, vecs[v].std, vecs[v].fsel, vecs[v].len, vecs[v].w_l);
      add_word(1'b1, vecs[v].std, vecs[v].fsel, vecs[v].len, vecs[v].w_r);
      add_raw(1'b0, 2, 64'd0);
      play();
      check($sformatf("vec%0d count", v), got_q.size(), vecs[v].n_exp);
      if (got_q.size() > 0) check($sformatf("vec%0d left", v), got_q[0], {1'b0, vecs[v].exp_l});
      if (vecs[v].n_exp > 1 && got_q.size() > 1)
        check($sformatf("vec%0d right", v), got_q[1], {1'b1, vecs[v].exp_r});
      check($sformatf("vec%0d frm_err", v), frm_err, 1'b0);
    end

    // Mono: four frames give four left words only
    setup(2'd0, 2'd0, 1'b0);
    add_raw(1'b1, 2, 64'd0);
    for (int i = 0; i < 4; i++) begin
      add_word(1'b0, 2'd0, 2'd0, 32, 32'h0100 + i);
      add_word(1'b1, 2'd0, 2'd0, 32, 32'h7700 + i);
    end
    add_raw(1'b0, 2, 64'd0);
    play();
    check("mono count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) check($sformatf("mono word%0d", i), got_q[i], 33'h0100 + i);

    // Overflow: six words into a four-deep FIFO with the consumer stalled
    rdy_mode = 0;
    setup(2'd0, 2'd0, 1'b1);
    add_raw(1'b1, 2, 64'd0);
    for (int i = 0; i < 6; i++) add_word(1'(i % 2), 2'd0, 2'd0, 32, 32'h1000 + i);
    add_raw(1'b0, 2, 64'd0);
    play();
    check("ovf set", ovf, 1'b1);
    check("ovf out_valid", out_if.out_valid, 1'b1);
    check("ovf stall data", out_if.out_data, 32'h1000);
    rdy_mode = 1;
    repeat (20) @(negedge pclk);
    check("ovf drained count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size())
        check($sformatf("ovf word%0d", i), got_q[i], {1'(i % 2), 32'h1000 + i});
    check("ovf still sticky", ovf, 1'b1);
    err_clr = 1'b1;
    @(negedge pclk);
    err_clr = 1'b0;
    @(negedge pclk);
    check("ovf cleared", ovf, 1'b0);

    // Philips 32 with ws toggling after 20 data bits
    setup(2'd0, 2'd2, 1'b1);
    add_raw(1'b1, 2, 64'd0);
    add_raw(1'b0, 21, 64'h0A5A5A);
    add_raw(1'b1, 2, 64'd0);
    play();
    check("short frm_err", frm_err, 1'b1);
    check("short no push", got_q.size(), 0);
    @(negedge pclk);
    en = 1'b0;
    repeat (3) @(negedge pclk);
    check("en low keeps frm_err", frm_err, 1'b1);

    // preset mid-word drops the partial word and waits for a fresh ws edge
    @(negedge pclk);
    std_sel = 2'd0;
    frame_sel = 2'd0;
    en = 1'b1;
    rdy_mode = 0;
    got_q.delete();
    add_raw(1'b1, 2, 64'd0);
    add_word(1'b0, 2'd0, 2'd0, 32, 32'h7777);
    add_raw(1'b1, 10, 64'h3FF);
    play();
    check("pre-reset out_valid", out_if.out_valid, 1'b1);
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    check("mid reset out_valid", out_if.out_valid, 1'b0);
    check("mid reset out_data", out_if.out_data, 32'd0);
    check("mid reset frm_err", frm_err, 1'b0);
    check("mid reset ovf", ovf, 1'b0);
    rdy_mode = 1;
    add_raw(1'b1, 30, 64'h2AAAAAAA);
    play();
    check("no word without ws edge", got_q.size(), 0);
    add_word(1'b0, 2'd0, 2'd0, 32, 32'h5A5A);
    add_raw(1'b1, 2, 64'd0);
    play();
    check("after reset count", got_q.size(), 1);
    if (got_q.size() > 0) check("after reset word", got_q[0], {1'b0, 32'h00005A5A});

    // Randomized streams against the slot-level model
    for (int it = 0; it < 8; it++) begin
      logic [1:0] s;
      logic [1:0] f;
      logic st;
      int n;
      int k;
      int len;
      s  = 2'($urandom_range(0, 3));
      f  = 2'($urandom_range(0, 3));
      st = 1'($urandom_range(0, 1));
      n  = n_of(f);
      rdy_mode = 2;
      setup(s, f, st);
      add_raw(1'b1, 2, {62'd0, 2'($urandom_range(0, 3))});
      k = $urandom_range(3, 6);
      for (int i = 0; i < k; i++) begin
        len = $urandom_range(n + 6, n - 3);
        add_raw(1'(i % 2), len, {$urandom(), $urandom()} & ((64'd1 << len) - 64'd1));
      end
      model_run(s, f, st);
      play();
      compare_all($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_rx_capture.md
# i2s_rx_capture

Oversampling I2S receiver in the `pclk` domain, placed downstream of the transceiver's serial pins. It consumes the `sclk`/`ws`/`sd` line driven by `I2S_top` in transmit mode, deserializes each channel word, and hands words to a consumer over a valid/ready port through a small FIFO. All logic runs on one clock: `sclk` is treated as data, oversampled and edge-detected, never used as a clock.

## Interface
Parameters:
- FIFO_DEPTH, 4, output word buffer depth; must be a power of 2, minimum 2.
- SYNC_STAGES, 2, synchronizer flops per serial input; minimum 2.

Ports:
- pclk  in  1  system clock; must be ≥ 4× the sclk frequency.
- preset  in  1  reset, synchronous, active-high.
- en  in  1  capture enable; low forces IDLE and flushes the FIFO.
- std_sel  in  2  0 = Philips, 1 = MSB-justified, 2 = LSB-justified, 3 = Philips.
- frame_sel  in  2  word length N: 0 = 16, 1 = 24, 2/3 = 32.
- stereo  in  1  1 = emit both channels; 0 = emit left (ws = 0) words only.
- sclk_i  in  1  asynchronous serial bit clock.
- ws_i  in  1  asynchronous word select (0 = left).
- sd_i  in  1  asynchronous serial data, MSB first.
- out_data  out  32  received word, right-aligned.
- out_right  out  1  channel of out_data (1 = right).
- out_valid  out  1  a word is available.
- out_ready  in  1  consumer accepts the word.
- ovf  out  1  sticky: a word was dropped because the FIFO was full.
- frm_err  out  1  sticky: a channel ended before N bits (Philips/MSB modes).
- err_clr  in  1  one-cycle pulse that clears ovf and frm_err.

## Operation
- Each serial input passes through SYNC_STAGES flops. `rise` is the synchronized sclk going 0→1 versus its registered previous value. ws and sd are sampled only on `rise`.
- `wsc` (ws change) is defined as ws sampled at this `rise` differing from ws sampled at the previous `rise`.
- States:
  - IDLE → (`wsc`) → SYNCED.
  - SYNCED: in Philips mode, go to DELAY. In MSB mode, go to SHIFT and shift in the current bit. In LSB mode, go to SHIFT and clear then shift.
  - DELAY → (next `rise`) → SHIFT, where that `rise` shifts in the MSB.
  - SHIFT: on each `rise`, shift sd into a 32-bit shifter and increment bit_cnt, saturating at 32.
- Philips/MSB commit: when bit_cnt reaches N, push the low N bits. The channel is the ws value of the current channel. Further bits are ignored until `wsc`.
- Philips/MSB `wsc` with bit_cnt < N: set frm_err, discard the word, restart per SYNCED rules.
- LSB commit: on `wsc`, push the low N bits of the shifter (bits up to the previous `rise`). Then clear the shifter and shift in the current bit. If fewer than N bits were received, zeros fill the upper bits; this is not an error.
- Mono (stereo = 0): right-channel words are never pushed.
- A push with the FIFO full drops the new word and sets ovf. FIFO contents are kept.
- err_clr has priority below a same-cycle set; a flag set in that cycle remains set.
- en low: state IDLE, FIFO flushed, shifter cleared, sticky flags kept.
- Configuration inputs are only changed while en = 0; behaviour otherwise is undefined.

## Timing
- Reset: all outputs 0, FIFO empty, state IDLE, synchronizers cleared.
- Latency: the push occurs one cycle after `rise`. out_valid is high in the cycle after the push if the FIFO was empty. From pin edge to out_valid is SYNC_STAGES + 2 pclk cycles.
- Handshake: a transfer occurs on a pclk edge with out_valid & out_ready. out_data and out_right are stable while out_valid & !out_ready.
- Push and pop in the same cycle with the FIFO full: the pop frees the slot and the push succeeds, so no ovf.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full is MSB differing with the rest equal.
- preset mid-word: the partial word is lost. The block re-enters IDLE and needs a fresh `wsc` before capturing.

## Configuration
- I2S_RX_SIGN_EXT_EN defined: out_data bits 31:N replicate bit N−1.
- Undefined: bits 31:N are zero.
- With N = 32 the two builds are identical.

## Structure
- `ctrl_pkg` gains the `rx_std_t` enum (PHILIPS, MSB_J, LSB_J) and the `rx_state_t` enum (IDLE, SYNCED, DELAY, SHIFT).
- `ctrl_pkg` also gains the frame-length function mapping frame_sel to N.
- Sub-module `i2s_pin_sync`: an SYNC_STAGES synchronizer for sclk/ws/sd plus the registered-previous edge detector. It outputs `rise`, `ws_s` and `sd_s`.
- The FIFO is inline.

## Test plan
- Philips, N = 16, stereo, sclk = pclk/8: left word 0xA5C3, right word 0x1234 → pops {0x0000A5C3, L} then {0x00001234, R}. With SIGN_EXT_EN the left word reads 0xFFFFA5C3.
- MSB-justified, N = 24, 32-bit slots: left 0x800001 → 0x00800001, or 0xFF800001 with the macro. The 8 trailing bits are ignored and frm_err stays 0.
- LSB-justified, N = 16, 32-bit slots: last 16 bits before the ws edge are 0xBEEF → out_data holds 0xBEEF, and leading bits are discarded.
- Mono mode, Philips 16-bit, 4 frames → exactly 4 left words, no right words.
- out_ready = 0, FIFO_DEPTH = 4, 6 words sent → 4 words retained in order, ovf = 1. err_clr → ovf = 0.
- Philips N = 32 with ws toggling after 20 bits → frm_err = 1, no push. preset asserted mid-word → outputs 0, no word until the next ws edge.
